reg_access_sequencer: RTL and testbench

- Operand-fetch and writeback sequencer directly upstream of the 16x32 single-port register file.
- Accepts one decoded instruction at a time: register indices plus control flags.
- Serialises up to two register reads over the file's single address port and presents the operands to the ALU stage.
- Accepts the ALU result and issues the register write.

---
 rtl/reg_access_sequencer_if.sv | 36 +++
 rtl/reg_access_sequencer.sv | 112 +++++++++++
 tb/tb_reg_access_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_access_sequencer_if.sv
// Handshake bundle between the decode stage, the sequencer and the ALU:
// instruction issue, operand hand-off and result writeback.
interface reg_access_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              issue_valid;
  logic              issue_ready;
  logic [ADDR_W-1:0] issue_src_a;
  logic [ADDR_W-1:0] issue_src_b;
  logic [ADDR_W-1:0] issue_dst;
  logic              issue_two_src;
  logic              issue_writeback;

  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;

  // master = decode/ALU side, slave = the sequencer
  modport master (
    output issue_valid, issue_src_a, issue_src_b, issue_dst,
           issue_two_src, issue_writeback, op_ready, wb_valid, wb_data,
    input  issue_ready, op_valid, op_a, op_b, wb_ready
  );

  modport slave (
    input  issue_valid, issue_src_a, issue_src_b, issue_dst,
           issue_two_src, issue_writeback, op_ready, wb_valid, wb_data,
    output issue_ready, op_valid, op_a, op_b, wb_ready
  );
endinterface

// File: rtl/reg_access_sequencer.sv
// Operand-fetch / writeback sequencer in front of a single-port register file.
// Serialises up to two reads, hands operands to the ALU, then writes the result.
module reg_access_sequencer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter bit PROTECT_R0 = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  reg_access_sequencer_if.slave bus,
  input  logic                  flush,
  output logic [ADDR_W-1:0]     rf_address,
  output logic [DATA_W-1:0]     rf_value,
  output logic                  rf_write,
  output logic                  rf_read,
  input  logic [DATA_W-1:0]     rf_data_out,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, CAP_B, CAP_A, OPS, WAIT_WB, WB
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] src_b_q;
  logic [ADDR_W-1:0] dst_q;
  logic              two_src_q;
  logic              writeback_q;
  logic              wr_blocked;

  assign wr_blocked = PROTECT_R0 && (dst_q == '0);

  // flush overrides every transition and always lands in IDLE
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.issue_valid) state_nxt = RD_A;
        RD_A:    state_nxt = two_src_q ? RD_B : CAP_A;
        RD_B:    state_nxt = CAP_B;
        CAP_B:   state_nxt = OPS;
        CAP_A:   state_nxt = OPS;
        OPS:     if (bus.op_ready) state_nxt = writeback_q ? WAIT_WB : IDLE;
        WAIT_WB: if (bus.wb_valid) state_nxt = WB;
        WB:      state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  // Read data arrives one edge after the strobe, hence the CAP_* states.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      src_b_q         <= '0;
      dst_q           <= '0;
      two_src_q       <= 1'b0;
      writeback_q     <= 1'b0;
      bus.op_a        <= '0;
      bus.op_b        <= '0;
      bus.op_valid    <= 1'b0;
      bus.wb_ready    <= 1'b0;
      bus.issue_ready <= 1'b1;
      busy            <= 1'b0;
      rf_address      <= '0;
      rf_value        <= '0;
      rf_write        <= 1'b0;
      rf_read         <= 1'b0;
    end else begin
      state           <= state_nxt;
      bus.issue_ready <= (state_nxt == IDLE);
      busy            <= (state_nxt != IDLE);
      bus.op_valid    <= (state_nxt == OPS);
      bus.wb_ready    <= (state_nxt == WAIT_WB);
      rf_read         <= (state_nxt == RD_A) || (state_nxt == RD_B);
      rf_write        <= (state_nxt == WB) && !wr_blocked;
      rf_value        <= ((state_nxt == WB) && !wr_blocked) ? bus.wb_data : '0;

      case (state_nxt)
        RD_A:    rf_address <= bus.issue_src_a;
        RD_B:    rf_address <= src_b_q;
        WB:      rf_address <= dst_q;
        default: rf_address <= '0;
      endcase

      if (!flush) begin
        case (state)
          IDLE: begin
            if (bus.issue_valid) begin
              src_b_q     <= bus.issue_src_b;
              dst_q       <= bus.issue_dst;
              two_src_q   <= bus.issue_two_src;
              writeback_q <= bus.issue_writeback;
            end
          end
          RD_B:  bus.op_a <= rf_data_out;
          CAP_B: bus.op_b <= rf_data_out;
          CAP_A: begin
            bus.op_a <= rf_data_out;
            bus.op_b <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Self-checking bench for reg_access_sequencer with a behavioural register file,
// a shadow register model and scoreboards for operand hand-offs and writes.
module tb_reg_access_sequencer;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 4;
  localparam bit PROTECT = 1'b1;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] rf_address;
  logic [DATA_W-1:0] rf_value;
  logic              rf_write;
  logic              rf_read;
  logic [DATA_W-1:0] rf_data_out;
  logic              busy;

  logic [DATA_W-1:0] rfMem  [16];
  logic [DATA_W-1:0] shadow [16];
  logic              preloadWe = 1'b0;
  logic [ADDR_W-1:0] preloadAddr = '0;
  logic [DATA_W-1:0] preloadData = '0;

  int compareCount = 0;
  int mismatchCount = 0;
  int hazardCount = 0;
  int unexpOps = 0;
  int unexpWr = 0;

  logic [63:0] expOps [$];
  logic [35:0] expWr  [$];
  logic [63:0] monOp;
  logic [35:0] monWr;

  reg_access_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_access_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PROTECT_R0(PROTECT)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .flush(flush),
    .rf_address(rf_address), .rf_value(rf_value), .rf_write(rf_write),
    .rf_read(rf_read), .rf_data_out(rf_data_out), .busy(busy)
  );

  always #5 clock = ~clock;

  // single-port register file: read data appears on the edge that samples rf_read
  always @(posedge clock) begin
    if (preloadWe) rfMem[preloadAddr] <= preloadData;
    else if (rf_write) rfMem[rf_address] <= rf_value;
    if (rf_read) rf_data_out <= rfMem[rf_address];
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (rf_read && rf_write) hazardCount++;
      if (!rf_write && rf_value != '0) hazardCount++;
      if (bus.op_valid && bus.op_ready) begin
        if (expOps.size() == 0) unexpOps++;
        else begin
          monOp = expOps.pop_front();
          checkOutput("opA", bus.op_a, monOp[63:32]);
          checkOutput("opB", bus.op_b, monOp[31:0]);
        end
      end
      if (rf_write) begin
        if (expWr.size() == 0) unexpWr++;
        else begin
          monWr = expWr.pop_front();
          checkOutput("wrAddr", rf_address, monWr[35:32]);
          checkOutput("wrData", rf_value, monWr[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [3:0] addr, input logic [31:0] data);
    preloadAddr = addr;
    preloadData = data;
    preloadWe   = 1'b1;
    tick();
    preloadWe   = 1'b0;
    shadow[addr] = data;
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                               input logic two, input logic wbk, input bit expectOps);
    int n;
    bus.issue_src_a     = a;
    bus.issue_src_b     = b;
    bus.issue_dst       = d;
    bus.issue_two_src   = two;
    bus.issue_writeback = wbk;
    bus.issue_valid     = 1'b1;
    n = 0;
    while (!bus.issue_ready && n < 50) begin tick(); n++; end
    checkOutput("issueReady", bus.issue_ready, 1);
    if (expectOps) expOps.push_back({shadow[a], two ? shadow[b] : 32'h0});
    tick();
    bus.issue_valid = 1'b0;
  endtask

  task automatic awaitOps(input int expLat, input int expReads, input logic [3:0] addr0, input logic [3:0] addr1);
    int lat;
    int nrd;
    logic [3:0] rd0;
    logic [3:0] rd1;
    lat = 0; nrd = 0; rd0 = '0; rd1 = '0;
    while (!bus.op_valid && lat < 20) begin
      if (rf_read) begin
        if (nrd == 0) rd0 = rf_address; else rd1 = rf_address;
        nrd++;
      end
      tick();
      lat++;
    end
    checkOutput("opLatency", lat, expLat);
    checkOutput("readCount", nrd, expReads);
    checkOutput("readAddr0", rd0, addr0);
    if (expReads > 1) checkOutput("readAddr1", rd1, addr1);
  endtask

  task automatic acceptOps(input int stall);
    logic [63:0] head;
    for (int i = 0; i < stall; i++) begin
      if (expOps.size() > 0) begin
        head = expOps[0];
        checkOutput("stallValid", bus.op_valid, 1);
        checkOutput("stallA", bus.op_a, head[63:32]);
        checkOutput("stallB", bus.op_b, head[31:0]);
      end
      tick();
    end
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
  endtask

  task automatic sendResult(input logic [31:0] data, input logic [3:0] d);
    int n;
    n = 0;
    while (!bus.wb_ready && n < 50) begin tick(); n++; end
    checkOutput("wbReady", bus.wb_ready, 1);
    if (!(PROTECT && d == 4'd0)) begin
      expWr.push_back({d, data});
      shadow[d] = data;
    end
    bus.wb_valid = 1'b1;
    bus.wb_data  = data;
    tick();
    bus.wb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int opSeen;
    bus.issue_valid = 1'b0; bus.issue_src_a = '0; bus.issue_src_b = '0; bus.issue_dst = '0;
    bus.issue_two_src = 1'b0; bus.issue_writeback = 1'b0;
    bus.op_ready = 1'b0; bus.wb_valid = 1'b0; bus.wb_data = '0;

    for (int i = 0; i < 16; i++) preload(4'(i), 32'h0);
    preload(4'd3, 32'h0000_00AA);
    preload(4'd7, 32'h1234_5678);
    #2 reset = 1'b1;
    tick();

    checkOutput("rstIssueReady", bus.issue_ready, 1);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstOpValid", bus.op_valid, 0);
    checkOutput("rstStrobes", {rf_read, rf_write, bus.wb_ready}, 0);
    checkOutput("rstOps", {bus.op_a, bus.op_b}, 0);

    $display("[TB] two-source read of R3/R7");
    applyStimulus(4'd3, 4'd7, 4'd0, 1'b1, 1'b0, 1'b1);
    awaitOps(3, 2, 4'd3, 4'd7);
    acceptOps(0);
    checkOutput("idleAfterOps", bus.issue_ready, 1);

    $display("[TB] single-source with stall and writeback to R5");
    applyStimulus(4'd7, 4'd0, 4'd5, 1'b0, 1'b1, 1'b1);
    awaitOps(2, 1, 4'd7, 4'd0);
    acceptOps(4);
    sendResult(32'hDEAD_BEEF, 4'd5);
    checkOutput("wbStrobe", rf_write, 1);
    checkOutput("wbAddr", rf_address, 5);
    tick();
    checkOutput("wbOneCycle", rf_write, 0);
    checkOutput("idleAfterWb", bus.issue_ready, 1);
    applyStimulus(4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    awaitOps(2, 1, 4'd5, 4'd0);
    acceptOps(0);

    $display("[TB] protected write to R0");
    applyStimulus(4'd3, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    awaitOps(2, 1, 4'd3, 4'd0);
    acceptOps(0);
    sendResult(32'hFFFF_FFFF, 4'd0);
    checkOutput("r0WbBusy", busy, 1);
    checkOutput("r0NoWrite", rf_write, 0);
    tick();
    checkOutput("r0Idle", bus.issue_ready, 1);
    applyStimulus(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    awaitOps(2, 1, 4'd0, 4'd0);
    acceptOps(0);

    $display("[TB] flush in WAIT_WB");
    applyStimulus(4'd3, 4'd0, 4'd9, 1'b0, 1'b1, 1'b1);
    awaitOps(2, 1, 4'd3, 4'd0);
    acceptOps(0);
    n = 0;
    while (!bus.wb_ready && n < 50) begin tick(); n++; end
    checkOutput("flushWbReady", bus.wb_ready, 1);
    flush = 1'b1; bus.wb_valid = 1'b1; bus.wb_data = 32'h0000_0099;
    tick();
    flush = 1'b0; bus.wb_valid = 1'b0;
    checkOutput("flushWbIdle", bus.issue_ready, 1);
    checkOutput("flushWbBusy", busy, 0);
    checkOutput("flushWbNoWrite", rf_write, 0);
    applyStimulus(4'd9, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    awaitOps(2, 1, 4'd9, 4'd0);
    acceptOps(0);

    $display("[TB] flush in RD_B");
    applyStimulus(4'd3, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("rdBAddr", rf_address, 7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flushRdBBusy", busy, 0);
    opSeen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.op_valid) opSeen++;
      tick();
    end
    checkOutput("flushRdBNoOps", opSeen, 0);

    $display("[TB] reset during RD_A");
    applyStimulus(4'd3, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("rdARead", rf_read, 1);
    #1 reset = 1'b0;
    #1;
    checkOutput("asyncRstRead", rf_read, 0);
    checkOutput("asyncRstBusy", busy, 0);
    checkOutput("asyncRstOut", {bus.op_valid, rf_write, rf_address}, 0);
    @(negedge clock);
    #1 reset = 1'b1;
    tick();
    applyStimulus(4'd7, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    awaitOps(2, 1, 4'd7, 4'd0);
    acceptOps(0);

    $display("[TB] back-to-back issue through R2");
    bus.issue_src_a = 4'd3; bus.issue_src_b = 4'd0; bus.issue_dst = 4'd2;
    bus.issue_two_src = 1'b0; bus.issue_writeback = 1'b1; bus.issue_valid = 1'b1;
    n = 0;
    while (!bus.issue_ready && n < 50) begin tick(); n++; end
    checkOutput("b2bReady1", bus.issue_ready, 1);
    expOps.push_back({shadow[3], 32'h0});
    tick();
    bus.issue_src_a = 4'd3; bus.issue_src_b = 4'd2; bus.issue_dst = 4'd0;
    bus.issue_two_src = 1'b1; bus.issue_writeback = 1'b0;
    awaitOps(2, 1, 4'd3, 4'd0);
    acceptOps(0);
    sendResult(32'h0000_0055, 4'd2);
    n = 0;
    while (!bus.issue_ready && n < 50) begin tick(); n++; end
    checkOutput("b2bReady2", bus.issue_ready, 1);
    expOps.push_back({shadow[3], shadow[2]});
    tick();
    bus.issue_valid = 1'b0;
    awaitOps(3, 2, 4'd3, 4'd2);
    acceptOps(0);

    repeat (3) tick();
    checkOutput("rdWrHazards", hazardCount, 0);
    checkOutput("unexpectedOps", unexpOps, 0);
    checkOutput("unexpectedWrites", unexpWr, 0);
    checkOutput("opsDrained", expOps.size(), 0);
    checkOutput("writesDrained", expWr.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
